// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if -- request/result bundle for alu_multicycle.
//   master : drives start, Ain, Bin, MODE; observes busy, done, ALUout, flags
//   slave  : the ALU side of the same signals
interface alu_multicycle_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [3:0]       MODE;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALUout;
    logic             FLAGzero;
    logic             FLAGneg;
    logic             FLAGcarry;
    logic             FLAGovf;
    logic             FLAGdivz;

    modport master (
        output start, Ain, Bin, MODE,
        input  busy, done, ALUout, FLAGzero, FLAGneg, FLAGcarry, FLAGovf, FLAGdivz
    );

    modport slave (
        input  start, Ain, Bin, MODE,
        output busy, done, ALUout, FLAGzero, FLAGneg, FLAGcarry, FLAGovf, FLAGdivz
    );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle -- 16-op ALU; multiply/divide/modulus are iterative
// (one bit per cycle), everything else completes in one cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_multicycle_if.slave (start/Ain/Bin/MODE in,
//              busy/done/ALUout/FLAG* out)
module alu_multicycle #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_multicycle_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1000;
    localparam logic [3:0] OP_MOD = 4'b1001;

    logic [1:0]       state;
    logic [3:0]       op;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] breg;   // multiplicand / divisor
    logic [WIDTH-1:0] acc;    // product high half / partial remainder
    logic [WIDTH-1:0] lo;     // multiplier->product low / dividend->quotient
    logic [WIDTH-1:0] res_q;
    logic             carry_q, ovf_q, divz_q;

    logic accept, multi;
    assign accept = bus.start && (state != RUN);
    // Divide by zero short-circuits to the single-cycle path.
    assign multi  = (bus.MODE == OP_MUL) ||
                    (((bus.MODE == OP_DIV) || (bus.MODE == OP_MOD)) && (bus.Bin != '0));

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] res_s;
    logic             c_s, v_s, z_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH-1:0] sub_s;

    assign add_s = {1'b0, bus.Ain} + {1'b0, bus.Bin};
    assign sub_s = bus.Ain - bus.Bin;

    always_comb begin
        res_s = '0;
        c_s   = 1'b0;
        v_s   = 1'b0;
        z_s   = 1'b0;
        case (bus.MODE)
            4'b0001: begin
                res_s = add_s[WIDTH-1:0];
                c_s   = add_s[WIDTH];
                v_s   = (bus.Ain[WIDTH-1] == bus.Bin[WIDTH-1]) &&
                        (add_s[WIDTH-1] != bus.Ain[WIDTH-1]);
            end
            4'b0010: begin
                res_s = sub_s;
                c_s   = bus.Ain < bus.Bin;
                v_s   = (bus.Ain[WIDTH-1] != bus.Bin[WIDTH-1]) &&
                        (sub_s[WIDTH-1] != bus.Ain[WIDTH-1]);
            end
            4'b0011: res_s = bus.Ain & bus.Bin;
            4'b0100: res_s = bus.Ain | bus.Bin;
            4'b0101: res_s = bus.Ain ^ bus.Bin;
            4'b0110: res_s = ~bus.Ain;
            OP_DIV:  begin res_s = '1;      z_s = 1'b1; end
            OP_MOD:  begin res_s = bus.Ain; z_s = 1'b1; end
            4'b1010: res_s = (bus.Bin >= WLIM) ? '0 : (bus.Ain << bus.Bin);
            4'b1011: res_s = (bus.Bin >= WLIM) ? '0 : (bus.Ain >> bus.Bin);
            4'b1100: res_s = bus.Ain;
            4'b1101: res_s = bus.Bin;
            4'b1110: res_s = {{(WIDTH-1){1'b0}}, bus.Ain != bus.Bin};
            4'b1111: res_s = {{(WIDTH-1){1'b0}}, bus.Ain <  bus.Bin};
            default: res_s = '0;
        endcase
    end

    // ---------------- iterative datapath ----------------
    // Multiply: {acc,lo} shifts right one bit per step, adding breg into
    // the high half when the current multiplier bit is set.
    logic [WIDTH:0]   msum;
    logic [WIDTH-1:0] mul_acc, mul_lo;
    assign msum    = {1'b0, acc} + (lo[0] ? {1'b0, breg} : '0);
    assign mul_acc = msum[WIDTH:1];
    assign mul_lo  = {msum[0], lo[WIDTH-1:1]};

    // Restoring divide: shift next dividend bit into the remainder and
    // subtract the divisor when it fits. Remainder < divisor always, so the
    // subtraction result fits in WIDTH bits.
    logic [WIDTH:0]   dshift;
    logic             dge;
    logic [WIDTH-1:0] div_acc, div_lo;
    assign dshift  = {acc, lo[WIDTH-1]};
    assign dge     = dshift >= {1'b0, breg};
    assign div_acc = dge ? (dshift[WIDTH-1:0] - breg) : dshift[WIDTH-1:0];
    assign div_lo  = {lo[WIDTH-2:0], dge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op      <= '0;
            cnt     <= '0;
            breg    <= '0;
            acc     <= '0;
            lo      <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            divz_q  <= 1'b0;
        end else if (accept) begin
            op   <= bus.MODE;
            breg <= bus.Bin;
            lo   <= bus.Ain;
            acc  <= '0;
            cnt  <= '0;
            if (multi) begin
                state <= RUN;
            end else begin
                state   <= FIN;
                res_q   <= res_s;
                carry_q <= c_s;
                ovf_q   <= v_s;
                divz_q  <= z_s;
            end
        end else begin
            case (state)
                RUN: begin
                    acc <= (op == OP_MUL) ? mul_acc : div_acc;
                    lo  <= (op == OP_MUL) ? mul_lo  : div_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state   <= FIN;
                        res_q   <= (op == OP_MUL) ? mul_lo :
                                   (op == OP_DIV) ? div_lo : div_acc;
                        carry_q <= (op == OP_MUL) && (mul_acc != '0);
                        ovf_q   <= 1'b0;
                        divz_q  <= 1'b0;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == FIN);
    assign bus.ALUout    = res_q;
    assign bus.FLAGzero  = (res_q == '0);
    assign bus.FLAGneg   = res_q[WIDTH-1];
    assign bus.FLAGcarry = carry_q;
    assign bus.FLAGovf   = ovf_q;
    assign bus.FLAGdivz  = divz_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=16). Status vector order:
// {done, busy, FLAGzero, FLAGneg, FLAGcarry, FLAGovf, FLAGdivz}.
module tb_alu_multicycle;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    alu_multicycle_if #(.WIDTH(16)) bus ();
    alu_multicycle #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [6:0] st();
        return {bus.done, bus.busy, bus.FLAGzero, bus.FLAGneg,
                bus.FLAGcarry, bus.FLAGovf, bus.FLAGdivz};
    endfunction

    // Present a request at a negedge; returns at the next negedge
    // (the cycle after the accepting edge) with start dropped.
    task automatic do_start(input logic [15:0] a, input logic [15:0] b, input logic [3:0] m);
        bus.Ain = a; bus.Bin = b; bus.MODE = m; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b1; bus.Ain = 16'h0001; bus.Bin = 16'h0001; bus.MODE = 4'b0001;
        repeat (2) @(negedge clk);
        total++; if (st() !== 7'b0010000) begin bad++; $display("FAIL reset_status got=%b exp=%b", st(), 7'b0010000); end
        total++; if (bus.ALUout !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h exp=%h", bus.ALUout, 16'h0000); end
        rst = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        total++; if (st() !== 7'b0010000) begin bad++; $display("FAIL reset_start_ignored got=%b exp=%b", st(), 7'b0010000); end
    endtask

    task automatic test_add();
        do_start(16'h7FFF, 16'h0001, 4'b0001);
        total++; if (bus.ALUout !== 16'h8000) begin bad++; $display("FAIL add_ovf_out got=%h exp=%h", bus.ALUout, 16'h8000); end
        total++; if (st() !== 7'b1001010) begin bad++; $display("FAIL add_ovf_status got=%b exp=%b", st(), 7'b1001010); end
        repeat (3) @(negedge clk);
        total++; if (bus.ALUout !== 16'h8000 || bus.done !== 1'b0) begin bad++; $display("FAIL add_hold got=%h/%b exp=%h/0", bus.ALUout, bus.done, 16'h8000); end
    endtask

    task automatic test_single();
        logic [3:0]  m  [16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                                 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1110, 4'b1111, 4'b1111};
        logic [15:0] a  [16] = '{16'h1234, 16'hFFFF, 16'h0003, 16'h8000, 16'h00F0, 16'h00F0, 16'h00FF, 16'h00F0,
                                 16'h0001, 16'h8000, 16'hABCD, 16'hABCD, 16'h0005, 16'h0005, 16'h0005, 16'h0006};
        logic [15:0] b  [16] = '{16'h5678, 16'h0001, 16'h0005, 16'h0001, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0000,
                                 16'h0004, 16'h000F, 16'h1111, 16'h1111, 16'h0005, 16'h0006, 16'h0006, 16'h0005};
        logic [15:0] e  [16] = '{16'h0000, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h0000, 16'h0FFF, 16'h0FF0, 16'hFF0F,
                                 16'h0010, 16'h0001, 16'hABCD, 16'h1111, 16'h0000, 16'h0001, 16'h0001, 16'h0000};
        logic [1:0]  cv [16] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00,
                                 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [6:0] exp_st;
        for (int i = 0; i < 16; i++) begin
            do_start(a[i], b[i], m[i]);
            exp_st = {1'b1, 1'b0, e[i] == 16'h0000, e[i][15], cv[i], 1'b0};
            total++; if (bus.ALUout !== e[i]) begin bad++; $display("FAIL single_out[%0d] mode=%b got=%h exp=%h", i, m[i], bus.ALUout, e[i]); end
            total++; if (st() !== exp_st) begin bad++; $display("FAIL single_status[%0d] mode=%b got=%b exp=%b", i, m[i], st(), exp_st); end
        end
    endtask

    task automatic test_mul();
        int n;
        do_start(16'h0100, 16'h0100, 4'b0111);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            bus.Ain = 16'hDEAD; bus.Bin = 16'hBEEF; bus.MODE = 4'b0000;  // must not disturb the run
            n++; @(negedge clk);
        end
        total++; if (n !== 16) begin bad++; $display("FAIL mul_busy_cycles got=%0d exp=16", n); end
        total++; if (bus.ALUout !== 16'h0000) begin bad++; $display("FAIL mul_out got=%h exp=%h", bus.ALUout, 16'h0000); end
        total++; if (st() !== 7'b1010100) begin bad++; $display("FAIL mul_status got=%b exp=%b", st(), 7'b1010100); end
        do_start(16'h00FF, 16'h0101, 4'b0111);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
        total++; if (bus.ALUout !== 16'hFFFF) begin bad++; $display("FAIL mul2_out got=%h exp=%h", bus.ALUout, 16'hFFFF); end
        total++; if (st() !== 7'b1001000) begin bad++; $display("FAIL mul2_status got=%b exp=%b", st(), 7'b1001000); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_start(16'd100, 16'd7, 4'b1000);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
        total++; if (n !== 16 || bus.done !== 1'b1) begin bad++; $display("FAIL div_latency got=%0d/%b exp=16/1", n, bus.done); end
        total++; if (bus.ALUout !== 16'd14) begin bad++; $display("FAIL div_out got=%0d exp=14", bus.ALUout); end
        do_start(16'd100, 16'd7, 4'b1001);   // issued on the done cycle
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mod_b2b_accept got=%b exp=1", bus.busy); end
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
        total++; if (bus.ALUout !== 16'd2) begin bad++; $display("FAIL mod_out got=%0d exp=2", bus.ALUout); end
        total++; if (st() !== 7'b1000000) begin bad++; $display("FAIL mod_status got=%b exp=%b", st(), 7'b1000000); end
    endtask

    task automatic test_divz();
        do_start(16'h1234, 16'h0000, 4'b1000);
        total++; if (bus.ALUout !== 16'hFFFF) begin bad++; $display("FAIL divz_q_out got=%h exp=%h", bus.ALUout, 16'hFFFF); end
        total++; if (st() !== 7'b1001001) begin bad++; $display("FAIL divz_q_status got=%b exp=%b", st(), 7'b1001001); end
        do_start(16'h1234, 16'h0000, 4'b1001);
        total++; if (bus.ALUout !== 16'h1234) begin bad++; $display("FAIL divz_r_out got=%h exp=%h", bus.ALUout, 16'h1234); end
        total++; if (st() !== 7'b1000001) begin bad++; $display("FAIL divz_r_status got=%b exp=%b", st(), 7'b1000001); end
    endtask

    task automatic test_abort();
        int seen;
        do_start(16'h0100, 16'h0100, 4'b0111);
        repeat (4) @(negedge clk);
        bus.Ain = 16'h0001; bus.Bin = 16'h0001; bus.MODE = 4'b0001; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.ALUout !== 16'h1234) begin bad++; $display("FAIL abort_ignore_start got=%b/%b/%h exp=1/0/1234", bus.busy, bus.done, bus.ALUout); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (st() !== 7'b0010000) begin bad++; $display("FAIL abort_status got=%b exp=%b", st(), 7'b0010000); end
        total++; if (bus.ALUout !== 16'h0000) begin bad++; $display("FAIL abort_out got=%h exp=%h", bus.ALUout, 16'h0000); end
        seen = 0;
        repeat (24) begin @(negedge clk); if (bus.done === 1'b1 || bus.busy === 1'b1) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    endtask

    task automatic test_shift();
        do_start(16'hFFFF, 16'd16, 4'b1010);
        total++; if (bus.ALUout !== 16'h0000 || st() !== 7'b1010000) begin bad++; $display("FAIL shl_sat got=%h/%b exp=0000/1010000", bus.ALUout, st()); end
        do_start(16'hFFFF, 16'd16, 4'b1011);
        total++; if (bus.ALUout !== 16'h0000 || st() !== 7'b1010000) begin bad++; $display("FAIL shr_sat got=%h/%b exp=0000/1010000", bus.ALUout, st()); end
        do_start(16'hFFFF, 16'hFFFF, 4'b1010);
        total++; if (bus.ALUout !== 16'h0000) begin bad++; $display("FAIL shl_big got=%h exp=%h", bus.ALUout, 16'h0000); end
        do_start(16'hFFFF, 16'd15, 4'b1011);
        total++; if (bus.ALUout !== 16'h0001) begin bad++; $display("FAIL shr_15 got=%h exp=%h", bus.ALUout, 16'h0001); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_single();
        test_mul();
        test_back_to_back();
        test_divz();
        test_abort();
        test_shift();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
